md_seq_ctrl: RTL and testbench

- Sequencing controller for the pipeline's shared multiply/divide unit and its HI/LO registers.
- Sits at the E stage. Decides when a mult/multu/div/divu may launch, counts its fixed latency, and strobes result commit into HI/LO.
- Gates mthi/mtlo writes and generates the F/D stall for HI/LO-dependent instructions.
- Arithmetic and the HI/LO storage live in a separate datapath. This block drives only its control strobes.

---
 rtl/md_pkg.sv | 40 ++++
 rtl/md_lat_counter.sv | 35 +++
 rtl/md_seq_ctrl.sv | 101 ++++++++++
 tb/tb_md_seq_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op classes, FSM states, latencies.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Also used by the decoder and the HI/LO datapath, so the op encoding must stay stable.
package md_pkg;

   // HI/LO op class carried down the pipeline. Codes 9..15 are unused
   // and every consumer treats them as OP_NONE.
   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   localparam int unsigned MD_MULT_LAT_DEF = 5;
   localparam int unsigned MD_DIV_LAT_DEF  = 10;
   localparam int unsigned MD_CNT_W_DEF    = 4;

   // True for the ops that occupy the shared multiply/divide unit.
   function automatic logic is_md(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // True for the long-latency divide ops.
   function automatic logic is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Down-counter that times a multiply/divide from launch to commit.
// Latency: load/decrement take effect at the next clk edge; expired is combinational on cnt.
// Backpressure: none; decrements whenever dec is high and cnt is non-zero.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset (cnt -> 0)
//   load, load_val  load a new count (load wins over dec)
//   dec             decrement by one this cycle
//   cnt             current count
//   expired         cnt == 1: the final cycle of the operation
module md_lat_counter #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             expired
);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expired = (cnt == CNT_W'(1));

endmodule

// File: rtl/md_seq_ctrl.sv
// Sequencing controller for the shared mult/div unit and the HI/LO registers (E stage).
// Latency: start is combinational; commit arrives LAT cycles after the launch cycle.
// Backpressure: stalls F/D (stall) while a HI/LO user sits in D and the unit is launching or busy.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset (aborts any operation in flight)
//   req          flush request for the E-stage instruction
//   e_valid      E holds a real instruction
//   e_op         HI/LO op class of the E instruction (md_pkg encoding)
//   d_hilo_use   D-stage instruction reads or writes HI/LO or uses the unit
//   start        launch pulse to the datapath; dp_op is valid while it is high
//   dp_op        op forwarded to the datapath, OP_NONE when not launching
//   commit       write the datapath result into HI/LO at this edge
//   wr_hi/wr_lo  mthi / mtlo write enables
//   busy         operation in flight
//   stall        freeze F/D and bubble E
module md_seq_ctrl
   import md_pkg::*;
#(
   parameter int unsigned MULT_LAT = MD_MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = MD_DIV_LAT_DEF,
   parameter int unsigned CNT_W    = MD_CNT_W_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic       e_valid,
   input  logic [3:0] e_op,
   input  logic       d_hilo_use,
   output logic       start,
   output logic [3:0] dp_op,
   output logic       commit,
   output logic       wr_hi,
   output logic       wr_lo,
   output logic       busy,
   output logic       stall
);

   md_state_e        state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] lat_sel;
   logic             expired;
   logic             e_live;

   // A live E instruction: real, not being flushed, and not squashed by a
   // reset in the same cycle (keeps every strobe low while reset is held).
   assign e_live  = e_valid && !req && !reset;
   assign lat_sel = is_div(e_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      commit    = 1'b0;
      wr_hi     = 1'b0;
      wr_lo     = 1'b0;
      case (state)
         ST_IDLE: begin
            start = e_live && is_md(e_op);
            wr_hi = e_live && (e_op == OP_MTHI);
            wr_lo = e_live && (e_op == OP_MTLO);
            if (start) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // req is deliberately ignored here: a launched op always commits.
            commit = expired && !reset;
            if (expired) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign dp_op = start ? e_op : OP_NONE;
   assign busy  = (state == ST_RUN);
   // The E instruction always advances; only the D-stage HI/LO user is held.
   assign stall = d_hilo_use && (start || busy);

   md_lat_counter #(
      .CNT_W (CNT_W)
   ) u_lat_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (start),
      .load_val (lat_sel),
      .dec      (busy),
      .cnt      (cnt),
      .expired  (expired)
   );

endmodule

// File: tb/tb_md_seq_ctrl.sv
module tb_md_seq_ctrl;
   import md_pkg::*;

   localparam int MLAT = 5;
   localparam int DLAT = 10;

   logic       clk = 1'b0;
   logic       reset, req, e_valid, d_hilo_use;
   logic [3:0] e_op;
   logic       start, commit, wr_hi, wr_lo, busy, stall;
   logic [3:0] dp_op;

   md_seq_ctrl #(.MULT_LAT(MLAT), .DIV_LAT(DLAT), .CNT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .e_valid    (e_valid),
      .e_op       (e_op),
      .d_hilo_use (d_hilo_use),
      .start      (start),
      .dp_op      (dp_op),
      .commit     (commit),
      .wr_hi      (wr_hi),
      .wr_lo      (wr_lo),
      .busy       (busy),
      .stall      (stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic       start;
      logic [3:0] dp_op;
      logic       commit;
      logic       wr_hi;
      logic       wr_lo;
      logic       busy;
      logic       stall;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   // Reference model: an operation is described only by the cycle it launched
   // and its latency. It is busy in cycles launch+1 .. launch+lat and commits
   // in cycle launch+lat.
   bit   op_open   = 1'b0;
   int   op_launch = 0;
   int   op_lat    = 0;

   task automatic chk(input string name, input int c, input logic [3:0] act, input logic [3:0] req_v);
      tests++;
      if (act !== req_v) begin
         fails++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, c, act, req_v);
      end
   endtask

   task automatic step(input bit rst, input bit v, input logic [3:0] op, input bit rq, input bit use_d);
      exp_t e;
      bit   in_flight, live, md_op;
      @(posedge clk);
      #1;
      reset      = rst;
      e_valid    = v;
      e_op       = op;
      req        = rq;
      d_hilo_use = use_d;

      in_flight = op_open && (cyc > op_launch) && (cyc <= op_launch + op_lat);
      live      = !rst && v && !rq && !in_flight;
      md_op     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);

      e.cyc    = cyc;
      e.start  = live && md_op;
      e.dp_op  = e.start ? op : OP_NONE;
      e.commit = !rst && in_flight && (cyc == op_launch + op_lat);
      e.wr_hi  = live && (op == OP_MTHI);
      e.wr_lo  = live && (op == OP_MTLO);
      e.busy   = in_flight;
      e.stall  = use_d && (e.start || in_flight);
      exp_q.push_back(e);

      if (rst) begin
         op_open = 1'b0;
      end else if (e.start) begin
         op_open   = 1'b1;
         op_launch = cyc;
         op_lat    = ((op == OP_DIV) || (op == OP_DIVU)) ? DLAT : MLAT;
      end else if (in_flight && (cyc == op_launch + op_lat)) begin
         op_open = 1'b0;
      end
      cyc++;
   endtask

   task automatic idle_n(input int n, input bit use_d);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, OP_NONE, 1'b0, use_d);
   endtask

   // Monitor: compares whatever the DUT presents mid-cycle against the oldest
   // expectation queued by the driver.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("start",  e.cyc, {3'b0, start},  {3'b0, e.start});
            chk("dp_op",  e.cyc, dp_op,          e.dp_op);
            chk("commit", e.cyc, {3'b0, commit}, {3'b0, e.commit});
            chk("wr_hi",  e.cyc, {3'b0, wr_hi},  {3'b0, e.wr_hi});
            chk("wr_lo",  e.cyc, {3'b0, wr_lo},  {3'b0, e.wr_lo});
            chk("busy",   e.cyc, {3'b0, busy},   {3'b0, e.busy});
            chk("stall",  e.cyc, {3'b0, stall},  {3'b0, e.stall});
         end
      end
   end

   initial begin
      reset = 1'b1; req = 1'b0; e_valid = 1'b0; e_op = OP_NONE; d_hilo_use = 1'b0;
      @(posedge clk);

      // Reset held for a few cycles, with a launch attempt that must be ignored.
      step(1'b1, 1'b0, OP_NONE, 1'b0, 1'b0);
      step(1'b1, 1'b1, OP_MULT, 1'b0, 1'b1);
      step(1'b1, 1'b0, OP_NONE, 1'b0, 1'b0);

      // mult launch and commit, D holding a HI/LO user throughout.
      step(1'b0, 1'b1, OP_MULT, 1'b0, 1'b1);
      idle_n(8, 1'b1);

      // div latency.
      step(1'b0, 1'b1, OP_DIV, 1'b0, 1'b1);
      idle_n(12, 1'b0);

      // req in the launch cycle suppresses the launch.
      step(1'b0, 1'b1, OP_DIVU, 1'b1, 1'b1);
      idle_n(12, 1'b1);

      // req while running does not cancel.
      step(1'b0, 1'b1, OP_MULTU, 1'b0, 1'b1);
      step(1'b0, 1'b0, OP_NONE, 1'b0, 1'b1);
      step(1'b0, 1'b1, OP_MFHI, 1'b1, 1'b1);
      idle_n(5, 1'b1);

      // Reset mid-divide, then a normal mult.
      step(1'b0, 1'b1, OP_DIV, 1'b0, 1'b1);
      idle_n(3, 1'b1);
      step(1'b1, 1'b0, OP_NONE, 1'b0, 1'b1);
      idle_n(8, 1'b1);
      step(1'b0, 1'b1, OP_MULT, 1'b0, 1'b0);
      idle_n(7, 1'b0);

      // mthi when idle, stall selectivity while busy, mtlo under req, ignored mthi while busy.
      step(1'b0, 1'b1, OP_MTHI, 1'b0, 1'b0);
      step(1'b0, 1'b1, OP_MULTU, 1'b0, 1'b0);
      step(1'b0, 1'b0, OP_NONE, 1'b0, 1'b0);
      step(1'b0, 1'b0, OP_NONE, 1'b0, 1'b1);
      step(1'b0, 1'b1, OP_MTHI, 1'b0, 1'b1);
      idle_n(4, 1'b0);
      step(1'b0, 1'b1, OP_MTLO, 1'b1, 1'b0);
      step(1'b0, 1'b1, OP_MTLO, 1'b0, 1'b0);
      step(1'b0, 1'b1, 4'd12, 1'b0, 1'b1);

      // Randomised traffic, including unknown op codes and stray resets.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 149) == 0,
              $urandom_range(0, 3) != 0,
              4'($urandom_range(0, 15)),
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 1) == 1);
      end

      idle_n(2, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
